bus_timer: RTL and testbench

- Memory-mapped programmable down-counter timer on the processor's data bus, downstream of the mips core.
- Selected by the system address decoder whenever a load or store falls in the timer window.
- Three word registers: CTRL, PRESET and COUNT.
- Counts down from PRESET and raises an interrupt request at terminal count. Two modes: one-shot and auto-reload.

---
 rtl/bus_timer_pkg.sv | 43 ++++
 rtl/bus_timer_if.sv | 30 +++
 rtl/bus_timer_fsm.sv | 94 +++++++++
 rtl/bus_timer.sv | 80 ++++++++
 tb/tb_bus_timer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped bus timer: register map, CTRL
// field layout, mode codes and FSM state encoding.
package bus_timer_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CTRL_W = 4;

    // Word offsets within the timer window (bus address [3:2])
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    // Mode codes; the two undefined codes fall back to one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Stored CTRL image; packed order matches the bus bit layout [3:0]
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Collapse the raw MODE field onto the two behaviours the timer has
    function automatic logic [1:0] eff_mode(input logic [1:0] mode);
        return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Data-bus slice seen by the timer: word offset, write strobe/data,
// combinational read data and the interrupt request back to the CPU.
interface bus_timer_if;
    import bus_timer_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BUS_W-1:0]  din;
    logic [BUS_W-1:0]  dout;
    logic              irq;

    // CPU / address-decoder side
    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    // Timer side
    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );

endinterface

// File: rtl/bus_timer_fsm.sv
// Timer sequencer: IDLE/LOAD/CNT/INT state register, COUNT down-counter and
// the terminal-count interrupt flag. CTRL itself lives in the register file;
// this block only requests that EN be cleared at one-shot terminal count.
module bus_timer_fsm
    import bus_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             ctrl_wr_i,
    input  logic [CNT_W-1:0] preset_i,
    output logic [CNT_W-1:0] count_o,
    output logic             int_flag_o,
    output logic             en_clr_c_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               int_flag_q, int_flag_d;
    logic               reload_c;

    assign reload_c   = (eff_mode(mode_i) == MODE_RELOAD);
    assign count_o    = count_q;
    assign int_flag_o = int_flag_q;

    // State, counter and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            int_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
        end
    end

    // Next-state, counter update and flag set/clear
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        int_flag_d = int_flag_q;
        en_clr_c_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset_i;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    // Flag and EN clear take effect on entry so irq lines up with INT
                    state_d    = ST_INT;
                    int_flag_d = 1'b1;
                    en_clr_c_o = !reload_c;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_INT: begin
                if (reload_c) begin
                    int_flag_d = 1'b0;
                    state_d    = en_i ? ST_LOAD : ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A CPU write to CTRL always acknowledges the interrupt, even at terminal count
        if (ctrl_wr_i) begin
            int_flag_d = 1'b0;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped programmable down-counter timer: CTRL/PRESET register file,
// write decode and read mux, with the sequencer in bus_timer_fsm.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    bus_timer_if.slave  bus
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count;
    logic               int_flag;
    logic               en_clr_c;
    logic               ctrl_wr_c;
    logic               preset_wr_c;

    assign ctrl_wr_c   = bus.we && (bus.addr == ADDR_CTRL);
    assign preset_wr_c = bus.we && (bus.addr == ADDR_PRESET);

    // Register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            preset_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
        end
    end

    // Write decode; a CPU CTRL write overrides the sequencer's EN clear
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;

        if (en_clr_c) begin
            ctrl_d.en = 1'b0;
        end
        if (ctrl_wr_c) begin
            ctrl_d.en   = bus.din[CTRL_EN_BIT];
            ctrl_d.mode = bus.din[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_d.im   = bus.din[CTRL_IM_BIT];
        end
        if (preset_wr_c) begin
            preset_d = bus.din[CNT_W-1:0];
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            ADDR_CTRL:   bus.dout = BUS_W'(CTRL_W'(ctrl_q));
            ADDR_PRESET: bus.dout = BUS_W'(preset_q);
            ADDR_COUNT:  bus.dout = BUS_W'(count);
            default:     bus.dout = '0;
        endcase
    end

    assign bus.irq = ctrl_q.im & int_flag;

    bus_timer_fsm #(
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .en_i       (ctrl_q.en),
        .mode_i     (ctrl_q.mode),
        .ctrl_wr_i  (ctrl_wr_c),
        .preset_i   (preset_q),
        .count_o    (count),
        .int_flag_o (int_flag),
        .en_clr_c_o (en_clr_c)
    );

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer. Expected COUNT/CTRL/irq come from a
// closed-form timeline: k edges after the starting CTRL write.
`timescale 1ns/1ps
module tb_bus_timer;
    import bus_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bus_timer_if bus_if ();

    bus_timer #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // One clock edge, optionally carrying a write; returns 1ns after the edge
    task automatic advance(input logic w, input logic [1:0] a, input logic [31:0] d);
        bus_if.we   = w;
        bus_if.addr = a;
        bus_if.din  = d;
        @(posedge clk);
        #1;
        bus_if.we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.addr = a;
        #1;
        d = bus_if.dout;
    endtask

    task automatic sample(output logic [31:0] cnt, output logic [31:0] ctrl, output logic irq);
        rd(ADDR_COUNT, cnt);
        rd(ADDR_CTRL, ctrl);
        irq = bus_if.irq;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Timeline after CTRL=c written at edge 0 from a freshly reset timer:
    // LOAD at 1, COUNT=p at 2, down to 0 at 2+p, INT at 3+p; reload repeats every p+3.
    function automatic void model(input longint k, input longint p, input logic [3:0] c,
                                  output logic [31:0] cnt, output logic irq,
                                  output logic [3:0] ctrl);
        longint j;
        cnt  = '0;
        irq  = 1'b0;
        ctrl = c;
        if (c[0] && k >= 2) begin
            if (c[2:1] == 2'b01) begin
                j = (k - 2) % (p + 3);
                if (j <= p) cnt = 32'(p - j);
                irq = c[3] && (j == p + 1);
            end else begin
                if (k - 2 <= p) cnt = 32'(p - (k - 2));
                if (k >= p + 3) begin
                    irq     = c[3];
                    ctrl[0] = 1'b0;
                end
            end
        end
    endfunction

    task automatic run_trial(input string name, input logic [31:0] p, input logic [3:0] c, input int ncyc);
        logic [31:0] cnt, ctrl, e_cnt;
        logic        irq, e_irq;
        logic [3:0]  e_ctrl;
        do_reset();
        advance(1'b1, ADDR_PRESET, p);
        advance(1'b1, ADDR_CTRL, 32'(c));
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) advance(1'b0, ADDR_COUNT, '0);
            sample(cnt, ctrl, irq);
            model(k, p, c, e_cnt, e_irq, e_ctrl);
            n_cmp += 3;
            if (cnt !== e_cnt) begin
                n_bad++; $display("FAIL %s count k=%0d p=%0d c=%h: got %h want %h", name, k, p, c, cnt, e_cnt);
            end
            if (ctrl !== 32'(e_ctrl)) begin
                n_bad++; $display("FAIL %s ctrl k=%0d p=%0d c=%h: got %h want %h", name, k, p, c, ctrl, e_ctrl);
            end
            if (irq !== e_irq) begin
                n_bad++; $display("FAIL %s irq k=%0d p=%0d c=%h: got %b want %b", name, k, p, c, irq, e_irq);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        #2;
        rd(ADDR_CTRL, v);   n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", v); end
        rd(ADDR_PRESET, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_preset: got %h want 0", v); end
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0", v); end
        n_cmp++; if (bus_if.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", bus_if.irq); end
        rst = 1'b1;
        // Reset asserted mid-count
        do_reset();
        advance(1'b1, ADDR_PRESET, 32'd100);
        advance(1'b1, ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 5; k++) advance(1'b0, ADDR_COUNT, '0);
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'd97) begin n_bad++; $display("FAIL midreset_pre_count: got %0d want 97", v); end
        rst = 1'b0;
        rd(ADDR_CTRL, v);   n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midreset_ctrl: got %h want 0", v); end
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midreset_count: got %h want 0", v); end
        n_cmp++; if (bus_if.irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %b want 0", bus_if.irq); end
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) advance(1'b0, ADDR_COUNT, '0);
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL postreset_count: got %h want 0", v); end
        rd(ADDR_CTRL, v);   n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL postreset_ctrl: got %h want 0", v); end
    endtask

    task automatic test_oneshot();
        logic [31:0] cnt, ctrl;
        logic        irq;
        run_trial("oneshot", 32'd3, 4'h9, 12);
        advance(1'b1, ADDR_CTRL, 32'h0);
        sample(cnt, ctrl, irq);
        n_cmp += 2;
        if (irq !== 1'b0)   begin n_bad++; $display("FAIL oneshot_ack_irq: got %b want 0", irq); end
        if (ctrl !== 32'h0) begin n_bad++; $display("FAIL oneshot_ack_ctrl: got %h want 0", ctrl); end
    endtask

    task automatic test_mask();
        logic [31:0] cnt, ctrl;
        logic        irq;
        run_trial("mask_p0", 32'd0, 4'h1, 8);
        advance(1'b1, ADDR_CTRL, 32'h8);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) advance(1'b0, ADDR_COUNT, '0);
            sample(cnt, ctrl, irq);
            n_cmp += 2;
            if (irq !== 1'b0)   begin n_bad++; $display("FAIL mask_unmask_irq k=%0d: got %b want 0", k, irq); end
            if (ctrl !== 32'h8) begin n_bad++; $display("FAIL mask_unmask_ctrl k=%0d: got %h want 8", k, ctrl); end
        end
    endtask

    // Write CTRL with EN=0 at edge kw of a running timer; COUNT freezes at its kw value
    task automatic test_stop(input logic [1:0] mode, input logic [31:0] p, input int kw);
        logic [31:0] cnt, ctrl, e_cnt, frz;
        logic        irq, e_irq, d_irq;
        logic [3:0]  e_ctrl, c_run, c_stop, d_ctrl;
        c_run  = {1'b1, mode, 1'b1};
        c_stop = {1'b1, mode, 1'b0};
        model(kw, p, c_run, frz, d_irq, d_ctrl);
        do_reset();
        advance(1'b1, ADDR_PRESET, p);
        advance(1'b1, ADDR_CTRL, 32'(c_run));
        for (int k = 1; k <= kw + 8; k++) begin
            advance(k == kw, ADDR_CTRL, 32'(c_stop));
            sample(cnt, ctrl, irq);
            if (k < kw) model(k, p, c_run, e_cnt, e_irq, e_ctrl);
            else begin e_cnt = frz; e_irq = 1'b0; e_ctrl = c_stop; end
            n_cmp += 3;
            if (cnt !== e_cnt)         begin n_bad++; $display("FAIL stop count k=%0d kw=%0d p=%0d m=%b: got %h want %h", k, kw, p, mode, cnt, e_cnt); end
            if (ctrl !== 32'(e_ctrl))  begin n_bad++; $display("FAIL stop ctrl k=%0d kw=%0d p=%0d m=%b: got %h want %h", k, kw, p, mode, ctrl, e_ctrl); end
            if (irq !== e_irq)         begin n_bad++; $display("FAIL stop irq k=%0d kw=%0d p=%0d m=%b: got %b want %b", k, kw, p, mode, irq, e_irq); end
        end
    endtask

    task automatic test_reload();
        run_trial("reload", 32'd2, 4'hB, 20);
        for (int kw = 1; kw <= 8; kw++) test_stop(2'b01, 32'd2, kw);
    endtask

    // CPU rewrites CTRL=0x9 on the very edge the one-shot would clear EN
    task automatic test_collision(input logic [31:0] p);
        logic [31:0] cnt, ctrl, e_cnt;
        logic        irq, e_irq;
        logic [3:0]  e_ctrl;
        int          kw;
        kw = 32'(p) + 3;
        do_reset();
        advance(1'b1, ADDR_PRESET, p);
        advance(1'b1, ADDR_CTRL, 32'h9);
        for (int k = 1; k <= kw + 2 * 32'(p) + 8; k++) begin
            advance(k == kw, ADDR_CTRL, 32'h9);
            sample(cnt, ctrl, irq);
            if (k < kw) model(k, p, 4'h9, e_cnt, e_irq, e_ctrl);
            else        model(k - (kw + 1), p, 4'h9, e_cnt, e_irq, e_ctrl);
            n_cmp += 3;
            if (cnt !== e_cnt)        begin n_bad++; $display("FAIL collide count k=%0d p=%0d: got %h want %h", k, p, cnt, e_cnt); end
            if (ctrl !== 32'(e_ctrl)) begin n_bad++; $display("FAIL collide ctrl k=%0d p=%0d: got %h want %h", k, p, ctrl, e_ctrl); end
            if (irq !== e_irq)        begin n_bad++; $display("FAIL collide irq k=%0d p=%0d: got %b want %b", k, p, irq, e_irq); end
        end
    endtask

    // PRESET rewritten mid-count only affects the next reload
    task automatic test_preset_midcount();
        logic [31:0] cnt, ctrl, e_cnt;
        logic        irq, e_irq;
        logic [3:0]  e_ctrl;
        do_reset();
        advance(1'b1, ADDR_PRESET, 32'd10);
        advance(1'b1, ADDR_CTRL, 32'hB);
        for (int k = 1; k <= 29; k++) begin
            advance(k == 7, ADDR_PRESET, 32'd4);
            sample(cnt, ctrl, irq);
            if (k < 15) model(k, 10, 4'hB, e_cnt, e_irq, e_ctrl);
            else        model(k - 13, 4, 4'hB, e_cnt, e_irq, e_ctrl);
            n_cmp += 2;
            if (cnt !== e_cnt) begin n_bad++; $display("FAIL midpreset count k=%0d: got %0d want %0d", k, cnt, e_cnt); end
            if (irq !== e_irq) begin n_bad++; $display("FAIL midpreset irq k=%0d: got %b want %b", k, irq, e_irq); end
        end
    endtask

    task automatic test_readback();
        logic [31:0] v;
        do_reset();
        advance(1'b1, ADDR_CTRL, 32'hFFFF_FFFF);
        rd(ADDR_CTRL, v); n_cmp++; if (v !== 32'hF) begin n_bad++; $display("FAIL rb_ctrl_mask: got %h want f", v); end
        do_reset();
        advance(1'b1, ADDR_PRESET, 32'd9);
        advance(1'b1, ADDR_CTRL, 32'h3);
        for (int k = 1; k <= 4; k++) advance(1'b0, ADDR_COUNT, '0);
        advance(1'b1, ADDR_CTRL, 32'h2);
        advance(1'b0, ADDR_COUNT, '0);
        advance(1'b1, ADDR_COUNT, 32'hDEAD);
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'd6) begin n_bad++; $display("FAIL rb_count_wr_ignored: got %0d want 6", v); end
        advance(1'b1, 2'd3, 32'h1234_5678);
        rd(2'd3, v);        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rb_addr3: got %h want 0", v); end
        rd(ADDR_CTRL, v);   n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL rb_ctrl_after_addr3: got %h want 2", v); end
        rd(ADDR_PRESET, v); n_cmp++; if (v !== 32'd9) begin n_bad++; $display("FAIL rb_preset: got %h want 9", v); end
        rd(ADDR_COUNT, v);  n_cmp++; if (v !== 32'd6) begin n_bad++; $display("FAIL rb_count_after_addr3: got %0d want 6", v); end
    endtask

    task automatic test_max_preset();
        run_trial("max_reload", 32'hFFFF_FFFF, 4'hB, 6);
        run_trial("max_oneshot", 32'hFFFF_FFFF, 4'h9, 6);
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [3:0]  c;
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(0, 12);
            c = 4'($urandom_range(0, 15));
            run_trial("random", p, c, 2 * (32'(p) + 3) + 6);
        end
        for (int i = 0; i < 10; i++) begin
            p = $urandom_range(0, 8);
            test_stop(2'($urandom_range(0, 3)), p, $urandom_range(1, 2 * (32'(p) + 3) + 2));
        end
        for (int i = 0; i < 3; i++) test_collision($urandom_range(0, 6));
    endtask

    initial begin
        bus_if.we   = 1'b0;
        bus_if.addr = '0;
        bus_if.din  = '0;
        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_preset_midcount();
        test_collision(32'd3);
        test_readback();
        test_max_preset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
